// File: rtl/sreg_pkg.sv
// Shared types and sizing for the pixel shift-register controller.
package sreg_pkg;

  localparam int PIX_W     = 42;
  localparam int SYM_W     = 2;
  localparam int NSYM      = PIX_W / SYM_W;
  localparam int SYM_IDX_W = $clog2(NSYM);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, SHIFT} sreg_state_t;

  typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/sreg_ctrl_pix_hold_buf.sv
// Single-entry valid/ready holding buffer for one pixel word.
module pix_hold_buf #(
  parameter int W = sreg_pkg::PIX_W
) (
  input  logic         sclk,
  input  logic         rst_n,
  input  logic         accept,
  input  logic         consume,
  input  logic [W-1:0] wr_data,
  output logic         full,
  output logic [W-1:0] data
);
  import sreg_pkg::*;

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // accept and consume never coincide: accept requires the buffer to be empty
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = wr_data;
    end else if (consume) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/sreg_ctrl.sv
// Serializes buffered pixel words into the shift register, two bits per symbol.
module sreg_ctrl #(
  parameter int PIX_W = sreg_pkg::PIX_W,
  parameter int SYM_W = sreg_pkg::SYM_W
) (
  input  logic                              sclk,
  input  logic                              rst_n,
  input  logic                              pix_valid,
  output logic                              pix_ready,
  input  logic [PIX_W-1:0]                  pix_data,
  output logic [PIX_W-1:0]                  pix_in,
  output logic                              load,
  output logic                              shift,
  output logic                              sym_strobe,
  output logic [$clog2(PIX_W/SYM_W)-1:0]    sym_idx,
  output logic                              frame_done,
  output logic                              busy
);
  import sreg_pkg::*;

  localparam int N_SYM = PIX_W / SYM_W;
  localparam int IDX_W = $clog2(N_SYM);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SYM - 1);

  if (PIX_W % SYM_W != 0) begin : g_bad_width
    $error("PIX_W must be a multiple of SYM_W");
  end

  sreg_state_t      state_q, state_d;
  logic [IDX_W-1:0] sym_cnt_q, sym_cnt_d;
  logic             load_q, load_d;
  logic             shift_q, shift_d;
  logic             strobe_q, strobe_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             buf_full;
  logic             last_sym;

  pix_hold_buf #(.W(PIX_W)) u_buf (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .accept  (pix_valid && !buf_full),
    .consume (state_q == LOAD),
    .wr_data (pix_data),
    .full    (buf_full),
    .data    (pix_in)
  );

  assign last_sym = (sym_cnt_q == LAST);

  // The register only refreshes sreg_out in a cycle with neither load nor
  // shift, so every symbol is followed by a HOLD before the next shift.
  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    unique case (state_q)
      IDLE:  if (buf_full) state_d = LOAD;
      LOAD: begin
        state_d   = HOLD;
        sym_cnt_d = '0;
      end
      HOLD: begin
        if (!last_sym)     state_d = SHIFT;
        else if (buf_full) state_d = LOAD;
        else               state_d = IDLE;
      end
      SHIFT: begin
        state_d   = HOLD;
        sym_cnt_d = sym_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    load_d   = (state_d == LOAD);
    shift_d  = (state_d == SHIFT);
    strobe_d = (state_q == HOLD);
    idx_d    = sym_cnt_q;
    done_d   = (state_q == HOLD) && last_sym;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sym_cnt_q <= '0;
      load_q    <= 1'b0;
      shift_q   <= 1'b0;
      strobe_q  <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      load_q    <= load_d;
      shift_q   <= shift_d;
      strobe_q  <= strobe_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
    end
  end

  assign pix_ready  = !buf_full;
  assign load       = load_q;
  assign shift      = shift_q;
  assign sym_strobe = strobe_q;
  assign sym_idx    = idx_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE) || buf_full;

endmodule

// File: tb/tb_sreg_ctrl.sv
// Self-checking bench for sreg_ctrl with a behavioural shift-register model and symbol scoreboard.
module tb_sreg_ctrl;
  import sreg_pkg::*;

  logic                 sclk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 pix_valid = 1'b0;
  logic [PIX_W-1:0]     pix_data = '0;
  logic                 pix_ready;
  logic [PIX_W-1:0]     pix_in;
  logic                 load;
  logic                 shift;
  logic                 sym_strobe;
  logic [SYM_IDX_W-1:0] sym_idx;
  logic                 frame_done;
  logic                 busy;

  always #5 sclk = ~sclk;

  sreg_ctrl dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_in     (pix_in),
    .load       (load),
    .shift      (shift),
    .sym_strobe (sym_strobe),
    .sym_idx    (sym_idx),
    .frame_done (frame_done),
    .busy       (busy)
  );

  // behavioural 42-bit shift register: sreg_out refreshes only when idle
  pix_t             sr_q;
  logic [SYM_W-1:0] sreg_out;
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= '0;
      sreg_out <= '0;
    end else if (load) begin
      sr_q <= pix_in;
    end else if (shift) begin
      sr_q <= sr_q >> SYM_W;
    end else begin
      sreg_out <= sr_q[SYM_W-1:0];
    end
  end

  typedef struct {
    logic [SYM_W-1:0] sym;
    int               idx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic prev_strobe = 1'b0;

  always @(negedge sclk) begin
    if (!rst_n) begin
      sb.delete();
      prev_strobe = 1'b0;
    end else begin
      n_checks++;
      if (load && shift) $display("FAIL load_shift_overlap: load=%0b shift=%0b required not both", load, shift);
      else n_pass++;
      n_checks++;
      if (sym_strobe && prev_strobe) $display("FAIL strobe_consecutive: strobe high two cycles at t=%0t", $time);
      else n_pass++;
      prev_strobe = sym_strobe;
      if (sym_strobe) begin
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL spurious_strobe: strobe idx=%0d with no symbol expected", sym_idx);
        end else begin
          n_pass++;
          e = sb.pop_front();
          n_checks++;
          if (sreg_out !== e.sym) $display("FAIL sb_symbol: got %0b expected %0b (idx %0d)", sreg_out, e.sym, e.idx);
          else n_pass++;
          n_checks++;
          if (sym_idx !== SYM_IDX_W'(e.idx)) $display("FAIL sb_idx: got %0d expected %0d", sym_idx, e.idx);
          else n_pass++;
          n_checks++;
          if (frame_done !== (e.idx == NSYM - 1)) $display("FAIL sb_frame_done: got %0b at idx %0d", frame_done, e.idx);
          else n_pass++;
        end
      end
      if (pix_valid && pix_ready)
        for (int k = 0; k < NSYM; k++) sb.push_back('{pix_data[k*SYM_W +: SYM_W], k});
    end
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (busy || sb.size() != 0) $display("FAIL drain_timeout: busy=%0b pending=%0d required idle and empty", busy, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pix_valid = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    n_checks++; if (load !== 1'b0) $display("FAIL rst_load: got %0b required 0", load); else n_pass++;
    n_checks++; if (shift !== 1'b0) $display("FAIL rst_shift: got %0b required 0", shift); else n_pass++;
    n_checks++; if (sym_strobe !== 1'b0) $display("FAIL rst_strobe: got %0b required 0", sym_strobe); else n_pass++;
    n_checks++; if (sym_idx !== '0) $display("FAIL rst_idx: got %0d required 0", sym_idx); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %0b required 0", frame_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b required 0", busy); else n_pass++;
    n_checks++; if (pix_ready !== 1'b1) $display("FAIL rst_ready: got %0b required 1", pix_ready); else n_pass++;
    n_checks++; if (pix_in !== '0) $display("FAIL rst_pix_in: got %0h required 0", pix_in); else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++; if (pix_ready !== 1'b1 || busy !== 1'b0) $display("FAIL post_rst_idle: ready=%0b busy=%0b required 1/0", pix_ready, busy); else n_pass++;
  endtask

  task automatic test_single();
    pix_t w = 42'h2AA_5555_5555;
    int   n_shift = 0;
    for (int c = 0; c <= 48; c++) begin
      pix_valid = (c == 0);
      pix_data  = w;
      n_checks++; if (load !== (c == 2)) $display("FAIL single_load c%0d: got %0b", c, load); else n_pass++;
      n_checks++; if (shift !== (c >= 4 && c <= 42 && c % 2 == 0)) $display("FAIL single_shift c%0d: got %0b", c, shift); else n_pass++;
      n_checks++; if (sym_strobe !== (c >= 4 && c <= 44 && c % 2 == 0)) $display("FAIL single_strobe c%0d: got %0b", c, sym_strobe); else n_pass++;
      n_checks++; if (frame_done !== (c == 44)) $display("FAIL single_frame_done c%0d: got %0b", c, frame_done); else n_pass++;
      if (c == 4) begin
        n_checks++; if (sreg_out !== 2'b01) $display("FAIL single_sym0: got %0b expected 01", sreg_out); else n_pass++;
      end
      if (c == 44) begin
        n_checks++; if (sreg_out !== 2'b10) $display("FAIL single_sym20: got %0b expected 10", sreg_out); else n_pass++;
      end
      if (shift) n_shift++;
      step();
    end
    pix_valid = 1'b0;
    n_checks++; if (n_shift != 20) $display("FAIL single_shift_count: got %0d expected 20", n_shift); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle: busy=%0b expected 0", busy); else n_pass++;
  endtask

  // three words offered back to back; the third sees backpressure
  task automatic test_back_to_back();
    pix_t w[3];
    int   acc[3];
    int   ptr = 0;
    logic accepted;
    w[0] = 42'h0AB_CDEF_0123;
    w[1] = 42'h3FF_0000_FFFF;
    w[2] = 42'h155_AAAA_5A5A;
    acc = '{-1, -1, -1};
    for (int c = 0; c <= 50; c++) begin
      pix_valid = (ptr < 3);
      if (ptr < 3) pix_data = w[ptr];
      n_checks++; if (load !== (c == 2 || c == 44)) $display("FAIL b2b_load c%0d: got %0b", c, load); else n_pass++;
      if (c >= 4 && c <= 44) begin
        n_checks++; if (pix_ready !== 1'b0) $display("FAIL b2b_backpressure c%0d: ready=%0b required 0", c, pix_ready); else n_pass++;
      end
      if (c == 45) begin
        n_checks++; if (pix_ready !== 1'b1) $display("FAIL b2b_ready_return: got %0b required 1", pix_ready); else n_pass++;
      end
      if (c == 44) begin
        n_checks++; if (frame_done !== 1'b1) $display("FAIL b2b_frame_done: got %0b required 1", frame_done); else n_pass++;
      end
      if (c == 46) begin
        n_checks++; if (sym_strobe !== 1'b1 || sym_idx !== '0) $display("FAIL b2b_word2_first: strobe=%0b idx=%0d required 1/0", sym_strobe, sym_idx); else n_pass++;
      end
      accepted = pix_valid && pix_ready;
      step();
      if (accepted) begin
        acc[ptr] = c;
        ptr++;
      end
    end
    pix_valid = 1'b0;
    n_checks++; if (acc[1] != 3) $display("FAIL b2b_accept2: cycle %0d expected 3", acc[1]); else n_pass++;
    n_checks++; if (acc[2] != 45) $display("FAIL b2b_accept3: cycle %0d expected 45", acc[2]); else n_pass++;
    wait_drain(200);
  endtask

  task automatic test_reset_mid();
    pix_t w1 = 42'h123_4567_89AB;
    pix_t w2 = 42'h2DB_6DB6_DB6E;
    for (int c = 0; c < 20; c++) begin
      pix_valid = (c == 0);
      pix_data  = w1;
      step();
    end
    pix_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (load !== 1'b0 || shift !== 1'b0) $display("FAIL mid_rst_ctl: load=%0b shift=%0b required 0/0", load, shift); else n_pass++;
    n_checks++; if (sym_strobe !== 1'b0 || sym_idx !== '0 || frame_done !== 1'b0) $display("FAIL mid_rst_strobe: strobe=%0b idx=%0d done=%0b required 0", sym_strobe, sym_idx, frame_done); else n_pass++;
    n_checks++; if (busy !== 1'b0 || pix_ready !== 1'b1) $display("FAIL mid_rst_state: busy=%0b ready=%0b required 0/1", busy, pix_ready); else n_pass++;
    repeat (2) step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_checks++; if (sym_strobe !== 1'b0 || load !== 1'b0) $display("FAIL mid_rst_quiet c%0d: strobe=%0b load=%0b required 0", c, sym_strobe, load); else n_pass++;
      step();
    end
    for (int c = 0; c <= 46; c++) begin
      pix_valid = (c == 0);
      pix_data  = w2;
      if (c == 4) begin
        n_checks++; if (sym_strobe !== 1'b1 || sym_idx !== '0 || sreg_out !== w2[1:0]) $display("FAIL mid_rst_restart: strobe=%0b idx=%0d sym=%0b required 1/0/%0b", sym_strobe, sym_idx, sreg_out, w2[1:0]); else n_pass++;
      end
      step();
    end
    pix_valid = 1'b0;
    wait_drain(100);
  endtask

  task automatic test_late_valid();
    pix_t w1 = 42'h0F0_F0F0_F0F0;
    pix_t w2 = 42'h30C_30C3_0C30;
    for (int c = 0; c <= 48; c++) begin
      pix_valid = (c == 0 || c == 43);
      pix_data  = (c < 43) ? w1 : w2;
      if (c == 43) begin
        n_checks++; if (pix_ready !== 1'b1) $display("FAIL late_ready: got %0b required 1", pix_ready); else n_pass++;
      end
      if (c == 44) begin
        n_checks++; if (load !== 1'b0 || shift !== 1'b0) $display("FAIL late_idle: load=%0b shift=%0b required 0/0", load, shift); else n_pass++;
        n_checks++; if (pix_ready !== 1'b0 || busy !== 1'b1) $display("FAIL late_buf_full: ready=%0b busy=%0b required 0/1", pix_ready, busy); else n_pass++;
      end
      if (c == 45) begin
        n_checks++; if (load !== 1'b1) $display("FAIL late_load: got %0b required 1", load); else n_pass++;
      end
      if (c == 47) begin
        n_checks++; if (sym_strobe !== 1'b1 || sym_idx !== '0) $display("FAIL late_first_strobe: strobe=%0b idx=%0d required 1/0", sym_strobe, sym_idx); else n_pass++;
      end
      step();
    end
    pix_valid = 1'b0;
    wait_drain(100);
  endtask

  task automatic test_soak();
    int          accepted = 0;
    int          cyc = 0;
    int          gap = 0;
    logic        acc;
    logic [63:0] r;
    pix_valid = 1'b0;
    while (accepted < 1000 && cyc < 70000) begin
      if (!pix_valid) begin
        if (gap == 0) begin
          r = {$urandom(), $urandom()};
          pix_valid = 1'b1;
          pix_data  = r[PIX_W-1:0];
        end else begin
          gap--;
        end
      end
      acc = pix_valid && pix_ready;
      step();
      cyc++;
      if (acc) begin
        accepted++;
        pix_valid = 1'b0;
        gap = $urandom_range(0, 60);
      end
    end
    pix_valid = 1'b0;
    n_checks++; if (accepted != 1000) $display("FAIL soak_count: accepted %0d required 1000", accepted); else n_pass++;
    wait_drain(200);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_late_valid();
    test_soak();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sreg_ctrl.md
# sreg_ctrl

Upstream controller for the 42-bit pixel shift register (`sreg_model`). It accepts pixel words on a valid/ready stream and holds one word in a single-entry buffer. It drives the register's `load`/`shift`/`pix_in` so that each word leaves as 21 two-bit symbols, LSB pair first. It also produces a strobe marking the cycles in which the register's `sreg_out` holds a fresh symbol.

## Interface
Parameters:
- `PIX_W`, 42, pixel word width; must equal the shift register width.
- `SYM_W`, 2, symbol width per shift; `PIX_W % SYM_W == 0` is checked at elaboration.

Ports:
- `sclk`  in  1  clock, shared with the shift register.
- `rst_n`  in  1  reset; asynchronous assert, active-low. Release is synchronous to `sclk` (synchronizer external).
- `pix_valid`  in  1  upstream word valid.
- `pix_ready`  out  1  buffer empty, word accepted when `pix_valid && pix_ready` at the rising edge.
- `pix_data`  in  PIX_W  upstream word.
- `pix_in`  out  PIX_W  to shift register; equals buffer contents.
- `load`  out  1  to shift register, one-cycle pulse.
- `shift`  out  1  to shift register, one-cycle pulse.
- `sym_strobe`  out  1  high in a cycle where `sreg_out` holds a new symbol.
- `sym_idx`  out  $clog2(PIX_W/SYM_W)  index of the strobed symbol, 0..20.
- `frame_done`  out  1  high with the strobe of the last symbol (index 20).
- `busy`  out  1  state ≠ IDLE or buffer full.

## Operation
- NSYM = PIX_W/SYM_W = 21.
- The shift register updates `sreg_out` only in cycles with `load=0` and `shift=0`, so every symbol needs a HOLD cycle.
- Buffer: `pix_buf` plus `buf_full`.
  - `pix_ready = !buf_full`.
  - An accept writes `pix_buf` and sets `buf_full`.
  - The LOAD state clears `buf_full`.
  - Accept and LOAD cannot coincide, because `pix_ready=0` while full.
- FSM states: IDLE, LOAD, HOLD, SHIFT. `load`/`shift` are Moore decodes of state (`load` = LOAD, `shift` = SHIFT).
  - IDLE → LOAD when `buf_full`, else stay.
  - LOAD → HOLD; `sym_cnt` ← 0.
  - HOLD → SHIFT if `sym_cnt < NSYM-1`.
  - HOLD → LOAD if `sym_cnt == NSYM-1` and `buf_full`.
  - HOLD → IDLE if `sym_cnt == NSYM-1` and not `buf_full`.
  - SHIFT → HOLD; `sym_cnt` ← `sym_cnt+1`.
- `sym_strobe`, `sym_idx` and `frame_done` are registered:
  - `sym_strobe` ← (state==HOLD).
  - `sym_idx` ← `sym_cnt`.
  - `frame_done` ← (state==HOLD && `sym_cnt==NSYM-1`).
- `sym_cnt` never exceeds NSYM-1; there is no wrap.
- Reset (async, any state):
  - state=IDLE, `buf_full`=0, `pix_buf`=0, `sym_cnt`=0.
  - Outputs: `load`=0, `shift`=0, `sym_strobe`=0, `sym_idx`=0, `frame_done`=0, `busy`=0, `pix_ready`=1.
  - An in-flight or buffered word is discarded, with no partial strobes after release.

## Timing
- Cycle 0: accept edge. Cycle 1: IDLE with `buf_full`. Cycle 2: LOAD. Cycle 3: HOLD.
- Symbol k is strobed in cycle 4+2k. `sreg_out = pix[2k+1:2k]` in that cycle.
- Symbol 20 is strobed in cycle 44 with `frame_done=1`.
- Back-to-back words: the next LOAD falls in cycle 44, giving a steady-state period of 42 cycles per word.
- `pix_ready` returns high the cycle after LOAD. An upstream word may be accepted at any time during HOLD/SHIFT of the current word.
- If `pix_valid` rises during the final HOLD with the buffer empty, the FSM passes through IDLE, adding 1 cycle versus a pre-buffered word.
- `sym_strobe` is never high in two consecutive cycles.

## Structure
- Package `sreg_pkg`:
  - `PIX_W`=42, `SYM_W`=2, `NSYM`, `SYM_IDX_W`.
  - `typedef enum logic [1:0] {IDLE, LOAD, HOLD, SHIFT} sreg_state_t`.
  - A `typedef logic [PIX_W-1:0] pix_t` shared with the shift register.
- One sub-module, `pix_hold_buf`: the single-entry valid/ready buffer, with ports `accept`, `consume`, `full`, `data`.
- FSM, counter and strobe registers live in `sreg_ctrl`.

## Test plan
- Single word: `pix_data=42'h2AA_5555_5555` accepted at cycle 0. Expect:
  - `load` only in cycle 2.
  - 20 `shift` pulses in cycles 4, 6, …, 42.
  - 21 strobes at cycles 4..44 with symbols 01 ×16 then 10 ×4 then 10.
  - `frame_done` only in cycle 44, then IDLE.
- Back-to-back: two words presented with `pix_valid` held high. Second accepted in cycle 3. Second `load` in cycle 44, first strobe of word 2 in cycle 46, `sym_idx` restarting at 0.
- Ready backpressure: third word offered while buffer full. `pix_ready=0` until the cycle after word 2's LOAD; no word dropped or duplicated, checked by an end-to-end scoreboard with a `sreg_model` instance.
- Reset mid-shift: `rst_n` pulled low at cycle 20 (asynchronous, between edges). All outputs go to reset values immediately, with no strobe after release. A new word after release is serialized from symbol 0.
- Late valid: `pix_valid` asserted in cycle 43 (final HOLD, buffer empty). Expect IDLE in cycle 44, `buf_full` in cycle 44, LOAD in cycle 45.
- Random stall soak: 1000 random words with random `pix_valid` gaps. The scoreboard matches every symbol. Assertions hold: `load && shift` never, and `sym_strobe` never in consecutive cycles.
